// File: rtl/ecc_enc_dec.sv
// APB-programmable extended-Hamming (SECDED) encoder/decoder, n=8 or n=16.
// Optional feature: define ECC_APB_READ_EN for combinational APB register read-back.
module ecc_enc_dec #(
    parameter int AMBA_WORD       = 16,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PENABLE,
    input  logic                       PSEL,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors
);

    typedef enum logic [1:0] {
        MODE_ENC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_FULL = 2'd2,
        MODE_NOP  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  errs;
    } dec_t;

    localparam logic [3:0] ADDR_CTRL  = 4'h0;
    localparam logic [3:0] ADDR_DATA  = 4'h4;
    localparam logic [3:0] ADDR_WIDTH = 4'h8;
    localparam logic [3:0] ADDR_NOISE = 4'hC;

    // Data bits fill non-power-of-two positions in ascending order; parity
    // bit p covers every position whose index has bit p set.
    function automatic logic [15:0] ecc_encode(input logic [15:0] d, input logic wide);
        logic [15:0] c;
        logic [3:0]  k;
        c = '0;
        k = '0;
        for (int i = 3; i < 16; i++) begin
            if (((i & (i - 1)) != 0) && (wide || i < 8)) begin
                c[i[3:0]] = d[k];
                k = k + 4'd1;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            for (int i = 1; i < 16; i++) begin
                if ((i & p) != 0) c[p[3:0]] = c[p[3:0]] ^ c[i[3:0]];
            end
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic dec_t ecc_decode(input logic [15:0] rx_in, input logic wide);
        logic [15:0] rx;
        logic [3:0]  syn;
        logic [3:0]  k;
        dec_t        res;
        rx  = wide ? rx_in : {8'h00, rx_in[7:0]};
        syn = '0;
        for (int i = 1; i < 16; i++) begin
            if (rx[i[3:0]]) syn = syn ^ i[3:0];
        end
        res.errs = 2'd0;
        if (^rx) begin
            // Odd overall parity: single error, syndrome 0 means c[0] itself.
            res.errs = 2'd1;
            rx[syn]  = ~rx[syn];
        end else if (syn != 4'd0) begin
            res.errs = 2'd2;
        end
        res.data = '0;
        k = '0;
        for (int i = 3; i < 16; i++) begin
            if (((i & (i - 1)) != 0) && (wide || i < 8)) begin
                res.data[k] = rx[i[3:0]];
                k = k + 4'd1;
            end
        end
        return res;
    endfunction

    logic [AMBA_WORD-1:0]  ctrl_q, ctrl_d;
    logic [AMBA_WORD-1:0]  data_in_q, data_in_d;
    logic [AMBA_WORD-1:0]  cw_width_q, cw_width_d;
    logic [AMBA_WORD-1:0]  noise_q, noise_d;
    logic                  start_q, start_d;
    mode_e                 op_mode_q, op_mode_d;
    logic [15:0]           op_data_q, op_data_d;
    logic                  op_wide_q, op_wide_d;
    logic [15:0]           op_noise_q, op_noise_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]            num_err_q, num_err_d;
    logic                  done_q, done_d;

    logic       wr_en;
    logic [3:0] addr;
    assign wr_en = PSEL & PENABLE & PWRITE;
    assign addr  = PADDR[3:0];

    // Operands are snapshotted at the CTRL write, so later register writes
    // cannot disturb an operation already in flight.
    always_comb begin
        // NOTE: every variable gets its hold value first so no latch is inferred.
        ctrl_d     = ctrl_q;
        data_in_d  = data_in_q;
        cw_width_d = cw_width_q;
        noise_d    = noise_q;
        start_d    = 1'b0;
        op_mode_d  = op_mode_q;
        op_data_d  = op_data_q;
        op_wide_d  = op_wide_q;
        op_noise_d = op_noise_q;
        if (wr_en) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_d = PWDATA;
                    if (mode_e'(PWDATA[1:0]) != MODE_NOP) begin
                        start_d    = 1'b1;
                        op_mode_d  = mode_e'(PWDATA[1:0]);
                        op_data_d  = data_in_q[15:0];
                        op_wide_d  = (cw_width_q != '0);
                        op_noise_d = noise_q[15:0];
                    end
                end
                ADDR_DATA:  data_in_d  = PWDATA;
                ADDR_WIDTH: cw_width_d = PWDATA;
                ADDR_NOISE: noise_d    = PWDATA;
                default: ;
            endcase
        end
    end

    logic [15:0] enc_word;
    dec_t        dec_res;

    always_comb begin
        enc_word   = ecc_encode(op_data_q, op_wide_q);
        dec_res    = ecc_decode(op_mode_q == MODE_FULL ? (enc_word ^ op_noise_q) : op_data_q,
                                op_wide_q);
        data_out_d = data_out_q;
        num_err_d  = num_err_q;
        done_d     = start_q;
        if (start_q) begin
            if (op_mode_q == MODE_ENC) begin
                data_out_d = DATA_WIDTH'(enc_word);
                num_err_d  = 2'd0;
            end else begin
                data_out_d = DATA_WIDTH'(dec_res.data);
                num_err_d  = dec_res.errs;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            data_in_q  <= '0;
            cw_width_q <= '0;
            noise_q    <= '0;
            start_q    <= 1'b0;
            op_mode_q  <= MODE_ENC;
            op_data_q  <= '0;
            op_wide_q  <= 1'b0;
            op_noise_q <= '0;
            data_out_q <= '0;
            num_err_q  <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            ctrl_q     <= ctrl_d;
            data_in_q  <= data_in_d;
            cw_width_q <= cw_width_d;
            noise_q    <= noise_d;
            start_q    <= start_d;
            op_mode_q  <= op_mode_d;
            op_data_q  <= op_data_d;
            op_wide_q  <= op_wide_d;
            op_noise_q <= op_noise_d;
            data_out_q <= data_out_d;
            num_err_q  <= num_err_d;
            done_q     <= done_d;
        end
    end

    assign data_out       = data_out_q;
    assign num_of_errors  = num_err_q;
    assign operation_done = done_q;

`ifdef ECC_APB_READ_EN
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (addr)
                ADDR_CTRL:  PRDATA = ctrl_q;
                ADDR_DATA:  PRDATA = data_in_q;
                ADDR_WIDTH: PRDATA = cw_width_q;
                ADDR_NOISE: PRDATA = noise_q;
                default:    PRDATA = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{PADDR[AMBA_ADDR_WIDTH-1:4]};
`else
    assign PRDATA = '0;

    logic unused_bits;
    assign unused_bits = ^{PADDR[AMBA_ADDR_WIDTH-1:4], ctrl_q};
`endif

endmodule

// File: tb/tb_ecc_enc_dec.sv
// Directed self-checking bench for ecc_enc_dec: reset, encode/decode/full
// channel at n=8 and n=16, no-op, output hold, back-to-back and mid-op reset.
module tb_ecc_enc_dec;

    logic        clk;
    logic        rst;
    logic [19:0] PADDR;
    logic        PENABLE;
    logic        PSEL;
    logic [15:0] PWDATA;
    logic        PWRITE;
    logic [15:0] PRDATA;
    logic [15:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int tests_run;
    int tests_failed;

    ecc_enc_dec #(
        .AMBA_WORD(16),
        .AMBA_ADDR_WIDTH(20),
        .DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .PADDR(PADDR),
        .PENABLE(PENABLE),
        .PSEL(PSEL),
        .PWDATA(PWDATA),
        .PWRITE(PWRITE),
        .PRDATA(PRDATA),
        .data_out(data_out),
        .operation_done(operation_done),
        .num_of_errors(num_of_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns #1 after the commit edge.
    task automatic apb_write(input logic [19:0] addr, input logic [15:0] data);
        @(posedge clk); #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = addr;
        PWDATA  = data;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (operation_done !== 1'b0 || data_out !== 16'h0 || num_of_errors !== 2'd0 || PRDATA !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_held: done=%b data=%h err=%0d prdata=%h, want 0/0000/0/0000",
                     operation_done, data_out, num_of_errors, PRDATA);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            tests_run++;
            if (operation_done !== 1'b0 || data_out !== 16'h0 || num_of_errors !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_release: done=%b data=%h err=%0d, want 0/0000/0",
                         operation_done, data_out, num_of_errors);
            end
        end
    endtask

    task automatic test_encode_n8;
        apb_write(20'h8, 16'h0);
        apb_write(20'h4, 16'h000B);
        apb_write(20'h0, 16'h0);
        tests_run++;
        if (operation_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL enc8_early: done=%b, want 0", operation_done);
        end
        @(posedge clk); #1;
        tests_run++;
        if (operation_done !== 1'b1 || data_out !== 16'h00AA || num_of_errors !== 2'd0) begin
            tests_failed++;
            $display("FAIL enc8: done=%b data=%h err=%0d, want 1/00aa/0",
                     operation_done, data_out, num_of_errors);
        end
        @(posedge clk); #1;
        tests_run++;
        if (operation_done !== 1'b0 || data_out !== 16'h00AA) begin
            tests_failed++;
            $display("FAIL enc8_pulse_width: done=%b data=%h, want 0/00aa", operation_done, data_out);
        end
    endtask

    task automatic test_decode_n8;
        apb_write(20'hC, 16'h0020);
        apb_write(20'h8, 16'h0);
        apb_write(20'h4, 16'h00AE);
        apb_write(20'h0, 16'h1);
        @(posedge clk); #1;
        tests_run++;
        if (operation_done !== 1'b1 || data_out !== 16'h000B || num_of_errors !== 2'd1) begin
            tests_failed++;
            $display("FAIL dec8: done=%b data=%h err=%0d, want 1/000b/1",
                     operation_done, data_out, num_of_errors);
        end
    endtask

    task automatic test_full_n8;
        logic [15:0] nz  [3] = '{16'h0004, 16'h0006, 16'h0001};
        logic [1:0]  ner [3] = '{2'd1, 2'd2, 2'd1};
        apb_write(20'h8, 16'h0);
        apb_write(20'h4, 16'h000B);
        for (int i = 0; i < 3; i++) begin
            apb_write(20'hC, nz[i]);
            apb_write(20'h0, 16'h2);
            @(posedge clk); #1;
            tests_run++;
            if (operation_done !== 1'b1 || data_out !== 16'h000B || num_of_errors !== ner[i]) begin
                tests_failed++;
                $display("FAIL full8 noise=%h: done=%b data=%h err=%0d, want 1/000b/%0d",
                         nz[i], operation_done, data_out, num_of_errors, ner[i]);
            end
        end
    endtask

    task automatic test_n16;
        logic [15:0] wid [5] = '{16'h1, 16'h1, 16'h1, 16'h1, 16'h5};
        logic [15:0] din [5] = '{16'h07FF, 16'hFFFF, 16'hFF7F, 16'hFFFC, 16'h07FF};
        logic [15:0] mde [5] = '{16'h0, 16'h1, 16'h1, 16'h1, 16'h0};
        logic [15:0] exd [5] = '{16'hFFFF, 16'h07FF, 16'h07FF, 16'h07FF, 16'hFFFF};
        logic [1:0]  exe [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 5; i++) begin
            apb_write(20'h8, wid[i]);
            apb_write(20'h4, din[i]);
            apb_write(20'h0, mde[i]);
            @(posedge clk); #1;
            tests_run++;
            if (operation_done !== 1'b1 || data_out !== exd[i] || num_of_errors !== exe[i]) begin
                tests_failed++;
                $display("FAIL n16 vec%0d: done=%b data=%h err=%0d, want 1/%h/%0d",
                         i, operation_done, data_out, num_of_errors, exd[i], exe[i]);
            end
        end
    endtask

    task automatic test_nop;
        apb_write(20'h0, 16'h3);
        repeat (3) begin
            tests_run++;
            if (operation_done !== 1'b0 || data_out !== 16'hFFFF || num_of_errors !== 2'd0) begin
                tests_failed++;
                $display("FAIL nop: done=%b data=%h err=%0d, want 0/ffff/0",
                         operation_done, data_out, num_of_errors);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold;
        apb_write(20'h4, 16'h1234);
        apb_write(20'hC, 16'h00FF);
        apb_write(20'h8, 16'h0);
        @(posedge clk); #1;
        tests_run++;
        if (operation_done !== 1'b0 || data_out !== 16'hFFFF || num_of_errors !== 2'd0) begin
            tests_failed++;
            $display("FAIL hold: done=%b data=%h err=%0d, want 0/ffff/0",
                     operation_done, data_out, num_of_errors);
        end
    endtask

    task automatic test_readback;
        apb_write(20'hC, 16'h0020);
        @(posedge clk); #1;
        PSEL   = 1'b1;
        PWRITE = 1'b0;
        PADDR  = 20'hC;
        #1;
        tests_run++;
`ifdef ECC_APB_READ_EN
        if (PRDATA !== 16'h0020) begin
            tests_failed++;
            $display("FAIL readback_noise: prdata=%h, want 0020", PRDATA);
        end
`else
        if (PRDATA !== 16'h0000) begin
            tests_failed++;
            $display("FAIL readback_disabled: prdata=%h, want 0000", PRDATA);
        end
`endif
        PSEL = 1'b0;
    endtask

    task automatic test_back_to_back;
        apb_write(20'h8, 16'h0);
        apb_write(20'h4, 16'h000B);
        @(posedge clk); #1;
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 20'h0;
        PWDATA  = 16'h0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        PWDATA  = 16'h1;
        @(posedge clk); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        tests_run++;
        if (operation_done !== 1'b1 || data_out !== 16'h00AA || num_of_errors !== 2'd0) begin
            tests_failed++;
            $display("FAIL b2b_first: done=%b data=%h err=%0d, want 1/00aa/0",
                     operation_done, data_out, num_of_errors);
        end
        @(posedge clk); #1;
        tests_run++;
        if (operation_done !== 1'b1 || data_out !== 16'h0001 || num_of_errors !== 2'd1) begin
            tests_failed++;
            $display("FAIL b2b_second: done=%b data=%h err=%0d, want 1/0001/1",
                     operation_done, data_out, num_of_errors);
        end
        @(posedge clk); #1;
        tests_run++;
        if (operation_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: done=%b, want 0", operation_done);
        end
    endtask

    task automatic test_reset_mid_op;
        apb_write(20'h0, 16'h1);
        rst = 1'b1;
        #1;
        tests_run++;
        if (operation_done !== 1'b0 || data_out !== 16'h0 || num_of_errors !== 2'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: done=%b data=%h err=%0d, want 0/0000/0",
                     operation_done, data_out, num_of_errors);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            tests_run++;
            if (operation_done !== 1'b0 || data_out !== 16'h0) begin
                tests_failed++;
                $display("FAIL rst_mid_no_pulse: done=%b data=%h, want 0/0000",
                         operation_done, data_out);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        PADDR   = '0;
        PENABLE = 1'b0;
        PSEL    = 1'b0;
        PWDATA  = '0;
        PWRITE  = 1'b0;
        test_reset();
        test_encode_n8();
        test_decode_n8();
        test_full_n8();
        test_n16();
        test_nop();
        test_hold();
        test_readback();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
